block_transfer_sequencer: RTL
=============================

BLOCK_TRANSFER_SEQUENCER -- requirements
Module: block_transfer_sequencer

Interface
REQ-001 Parameter ADDRESS_LEN, default 32, instruction word width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instruction  input  ADDRESS_LEN  word currently in decode.
REQ-005 cond_pass  input  1  condition check result for instruction.
REQ-006 Hazard  input  1  decode stall request.
REQ-007 flush  input  1  taken-branch flush; aborts any sequence.
REQ-008 cycle_freeze  output  1  hold fetch and decode registers.
REQ-009 uop_valid  output  1  micro-op presented this cycle.
REQ-010 uop_reg  output  4  register transferred by the micro-op.
REQ-011 uop_load  output  1  1 = load (L bit), 0 = store.
REQ-012 uop_base  output  4  base register Rn.
REQ-013 uop_offset  output  6  byte offset: 4 × micro-op index.
REQ-014 uop_base_wb  output  1  micro-op is the base writeback.
REQ-015 seq_done  output  1  one-cycle pulse on the final micro-op.

Function
REQ-016 Block-transfer class: instruction[27:25]==3'b100; list=[15:0], Rn=[19:16], L=[20], W=[21].
REQ-017 States: IDLE, ISSUE, WBASE.
REQ-018 Start condition: IDLE, class match, cond_pass=1, Hazard=0, flush=0, list!=0.
REQ-019 On the start edge: latch list, Rn, L, W; clear index to 0; go to ISSUE.
REQ-020 IDLE outputs: uop_valid=0, seq_done=0; cycle_freeze=1 only in the start cycle.
REQ-021 ISSUE cycle, Hazard=0: uop_valid=1; uop_reg = lowest set bit of the latched list; uop_offset = index×4.
REQ-022 ISSUE edge, Hazard=0: clear that bit and increment index.
REQ-023 ISSUE, Hazard=1: uop_valid=0; the list, index and state hold.
REQ-024 Leaving ISSUE: when the last set bit issues, go to WBASE if W=1 and writeback is compiled in; otherwise go to IDLE.
REQ-025 WBASE cycle, Hazard=0: uop_valid=1, uop_base_wb=1, uop_offset = total count×4; next state IDLE.
REQ-026 cycle_freeze is 1 in every ISSUE/WBASE cycle except the final micro-op cycle with Hazard=0.
REQ-027 seq_done=1 exactly in the final micro-op cycle.
REQ-028 Latency: N set bits take N+1 (+1 with WBASE) cycles from start to freeze release, excluding Hazard cycles.
REQ-029 Empty list, failed condition, or non-class word: no sequence starts and all outputs stay 0.
REQ-030 flush=1 in any state: uop_valid=0 that cycle; next state IDLE; flush overrides Hazard and start.
REQ-031 A 16-bit list issues 16 micro-ops; index saturates at 15; uop_offset maximum is 60.

Reset
REQ-032 rst=1 immediately forces IDLE, clears list/index/latches, and drives all outputs to 0, including mid-sequence.

Configuration
REQ-033 Macro BLOCK_TRANSFER_WRITEBACK_EN: when defined, W=1 appends the WBASE micro-op.
REQ-034 When it is undefined, WBASE is unreachable, the W bit is ignored, and uop_base_wb is tied to 0.

Structure
REQ-035 State encodings and the class opcode 3'b100 are defined in configs.v.
REQ-036 Lowest-set-bit priority encoding is one sub-module, lowest_set_bit (16-bit in, 4-bit index plus valid out).

Verification
REQ-037 List 16'h0005, L=1, Rn=13, W=0 -> uops reg0/off0 then reg2/off4; seq_done on the second; freeze 1,1,0.
REQ-038 List 16'h0003 with Hazard=1 on the first ISSUE cycle -> one idle cycle, then reg0/off0 and reg1/off4; freeze held throughout.
REQ-039 List 16'h8001, W=1, macro defined -> reg0/off0, reg15/off4, then base_wb/off8; undefined -> no third uop.
REQ-040 List 16'h00F0 with flush on the second ISSUE cycle -> only reg4 issued; IDLE next; freeze 0.
REQ-041 List 16'hFFFF -> 16 uops, offsets 0..60; rst mid-sequence -> all outputs 0 asynchronously.
REQ-042 List 16'h0000 or cond_pass=0 -> no uop_valid and no freeze.

Source files
------------

// File: rtl/block_transfer_sequencer_pkg.sv
// Shared definitions for the block-transfer sequencer: field widths,
// state encoding, the block-transfer class opcode and an offset helper.
package block_transfer_sequencer_pkg;

    localparam int unsigned LIST_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OFF_W  = 6;

    // instruction[27:25] value that marks a block-transfer word
    localparam logic [2:0] BT_CLASS = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WBASE = 2'd2
    } bts_state_e;

    // Byte offset of a micro-op: four bytes per transferred register
    function automatic logic [OFF_W-1:0] offset_of(input logic [REG_W-1:0] idx);
        return OFF_W'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/block_transfer_sequencer_lowest_set_bit.sv
// lowest_set_bit: priority encoder returning the index of the lowest set
// bit of a 16-bit vector.
//   vec   - input vector
//   idx   - index of the lowest set bit (0 when vec is zero)
//   valid - vec has at least one bit set
module lowest_set_bit
    import block_transfer_sequencer_pkg::*;
(
    input  logic [LIST_W-1:0] vec,
    output logic [REG_W-1:0]  idx,
    output logic              valid
);

    // Scan from the top down so the lowest set bit wins the last assignment
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = REG_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer: expands a block-transfer (load/store multiple)
// instruction into one micro-op per listed register, optionally followed by
// a base-writeback micro-op, while freezing fetch/decode.
//
// Configuration macro: BLOCK_TRANSFER_WRITEBACK_EN -- when defined, W=1
// appends a WBASE micro-op; otherwise the W bit is ignored and uop_base_wb
// is tied to 0.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   instruction     - word in decode (list=[15:0] Rn=[19:16] L=[20] W=[21])
//   cond_pass       - condition check passed for the word
//   Hazard          - decode stall request
//   flush           - taken-branch flush, aborts any sequence
//   cycle_freeze    - hold fetch and decode registers
//   uop_valid       - micro-op presented this cycle
//   uop_reg         - register transferred
//   uop_load        - 1 load, 0 store
//   uop_base        - base register Rn
//   uop_offset      - byte offset of the micro-op
//   uop_base_wb     - micro-op is the base writeback
//   seq_done        - pulse on the final micro-op
module block_transfer_sequencer
    import block_transfer_sequencer_pkg::*;
#(
    parameter int unsigned ADDRESS_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRESS_LEN-1:0] instruction,
    input  logic                   cond_pass,
    input  logic                   Hazard,
    input  logic                   flush,
    output logic                   cycle_freeze,
    output logic                   uop_valid,
    output logic [REG_W-1:0]       uop_reg,
    output logic                   uop_load,
    output logic [REG_W-1:0]       uop_base,
    output logic [OFF_W-1:0]       uop_offset,
    output logic                   uop_base_wb,
    output logic                   seq_done
);

    bts_state_e        state;
    logic [LIST_W-1:0] list_q;
    logic [REG_W-1:0]  rn_q;
    logic [REG_W-1:0]  idx_q;
    logic              load_q;

    logic [REG_W-1:0]  lsb_idx;
    logic              lsb_valid;
    logic              class_match;
    logic              start;
    logic              last_bit;
    logic              issue_go;
    logic              wb_go;
    logic              goto_wb;
    logic              final_uop;
    logic              unused_bits;

`ifdef BLOCK_TRANSFER_WRITEBACK_EN
    logic              wb_q;
    assign goto_wb     = wb_q;
    assign unused_bits = ^{instruction[ADDRESS_LEN-1:28], instruction[24:22]};
`else
    assign goto_wb     = 1'b0;
    assign unused_bits = ^{instruction[ADDRESS_LEN-1:28], instruction[24:21]};
`endif

    lowest_set_bit u_lsb (
        .vec   (list_q),
        .idx   (lsb_idx),
        .valid (lsb_valid)
    );

    // Decode-side and sequence-side qualifiers
    assign class_match = (instruction[27:25] == BT_CLASS);
    assign start       = (state == ST_IDLE) && class_match && cond_pass && !Hazard
                         && !flush && (instruction[15:0] != '0);
    // Only one bit remains when clearing the lowest leaves nothing
    assign last_bit    = ((list_q & (list_q - LIST_W'(1))) == '0);
    assign issue_go    = (state == ST_ISSUE) && !Hazard && !flush && lsb_valid;
`ifdef BLOCK_TRANSFER_WRITEBACK_EN
    assign wb_go       = (state == ST_WBASE) && !Hazard && !flush;
`else
    assign wb_go       = 1'b0;
`endif
    assign final_uop   = (issue_go && last_bit && !goto_wb) || wb_go;

    // Sequence state, latched fields and micro-op index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            list_q <= '0;
            rn_q   <= '0;
            idx_q  <= '0;
            load_q <= 1'b0;
`ifdef BLOCK_TRANSFER_WRITEBACK_EN
            wb_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        list_q <= instruction[15:0];
                        rn_q   <= instruction[19:16];
                        load_q <= instruction[20];
`ifdef BLOCK_TRANSFER_WRITEBACK_EN
                        wb_q   <= instruction[21];
`endif
                        idx_q  <= '0;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (issue_go) begin
                        list_q <= list_q & ~(LIST_W'(1) << lsb_idx);
                        // Saturate so a full 16-register list stays at offset 60
                        if (idx_q != REG_W'(LIST_W - 1)) begin
                            idx_q <= idx_q + REG_W'(1);
                        end
                        if (last_bit) begin
                            state <= goto_wb ? ST_WBASE : ST_IDLE;
                        end
                    end
                end
                ST_WBASE: begin
                    if (flush || !Hazard) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Micro-op outputs; reset gates them so they drop without waiting for an edge
    always_comb begin
        cycle_freeze = 1'b0;
        uop_valid    = 1'b0;
        uop_reg      = '0;
        uop_load     = 1'b0;
        uop_base     = '0;
        uop_offset   = '0;
        uop_base_wb  = 1'b0;
        seq_done     = 1'b0;
        if (!rst) begin
            if (state == ST_IDLE) begin
                cycle_freeze = start;
            end else begin
                cycle_freeze = !final_uop;
            end
            if (issue_go || wb_go) begin
                uop_valid   = 1'b1;
                uop_reg     = issue_go ? lsb_idx : '0;
                uop_load    = load_q;
                uop_base    = rn_q;
                uop_offset  = offset_of(idx_q);
                uop_base_wb = wb_go;
            end
            seq_done = final_uop;
        end
    end

endmodule
